// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by the fetch unit and its next-PC helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;  // addi x0,x0,0
  localparam int unsigned PC_INCR   = 4;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory bus: valid/ready request channel plus a valid-only response.
// The fetch unit is the master, instruction memory the slave.
interface fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_rsp_valid;
  logic [DATA_WIDTH-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: redirect, taken branch or sequential advance.
// All results are word-aligned and wrap modulo 2^ADDR_WIDTH.
module pc_next_calc
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  PCsrc,
  input  logic [DATA_WIDTH-1:0] ImmOp,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic [ADDR_WIDTH-1:0] pc_next
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  logic [ADDR_WIDTH-1:0] imm_ext;

  always_comb begin
    imm_ext = ADDR_WIDTH'($signed(ImmOp));
    if (redirect_valid) begin
      pc_next = redirect_addr & ALIGN_MASK;
    end else if (PCsrc) begin
      pc_next = (pc + imm_ext) & ALIGN_MASK;
    end else begin
      pc_next = pc + ADDR_WIDTH'(PC_INCR);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// holds the returned instruction until decode consumes it or a redirect drops it.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_if.master               imem,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  PCsrc,
  input  logic [DATA_WIDTH-1:0] ImmOp,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr
);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  squash;

  pc_next_calc #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pc_next (
    .pc            (pc),
    .PCsrc         (PCsrc),
    .ImmOp         (ImmOp),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .pc_next       (pc_next)
  );

  assign imem.imem_req_valid = (state == FETCH) && !rst;
  assign imem.imem_addr      = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      squash      <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= DATA_WIDTH'(INSTR_NOP);
      instr_pc    <= RESET_PC;
    end else begin
      if (redirect_valid || (state == HOLD && instr_ready)) begin
        pc <= pc_next;
      end
      unique case (state)
        FETCH: begin
          if (imem.imem_req_ready) begin
            state  <= WAIT;
            squash <= redirect_valid;
          end
        end
        WAIT: begin
          // A response coinciding with a redirect is dropped outright, so squash
          // only needs to cover responses still to come.
          if (imem.imem_rsp_valid) begin
            squash <= 1'b0;
            if (squash || redirect_valid) begin
              state <= FETCH;
            end else begin
              instr       <= imem.imem_rsp_data;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              state       <= HOLD;
            end
          end else if (redirect_valid) begin
            squash <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid || instr_ready) begin
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized traffic checked
// against a transaction-level PC/memory reference model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          AW     = 32;
  localparam int          DW     = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [AW-1:0] instr_pc;
  logic          PCsrc;
  logic [DW-1:0] ImmOp;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;

  fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) imem_bus ();

  fetch_unit #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (imem_bus.master),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_pc      (instr_pc),
    .PCsrc         (PCsrc),
    .ImmOp         (ImmOp),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // reference state: architectural PC and the memory's single pending request
  logic [31:0] exp_pc;
  logic        m_out;
  logic [31:0] m_addr;
  int unsigned m_cnt;
  int unsigned ready_mode;  // 0 random, 1 always ready, 2 never ready
  int unsigned lat_fix;     // 0 random latency 1..4
  logic        force_rsp;
  int unsigned n_pres;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h0010_0113;
      32'h0000_0020: return 32'hDEAD_BEEF;
      default:       return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endcase
  endfunction

  task automatic model_check();
    if (m_out) check_eq("single_outstanding", 32'(imem_bus.imem_req_valid), 32'd0);
    if (instr_valid) begin
      check_eq("instr_pc", instr_pc, exp_pc);
      check_eq("instr", instr, memf(exp_pc));
      check_eq("no_req_in_hold", 32'(imem_bus.imem_req_valid), 32'd0);
    end
    if (imem_bus.imem_req_valid) check_eq("imem_addr", imem_bus.imem_addr, exp_pc);
  endtask

  // one clock: memory responds, reference advances, then the edge and checks
  task automatic clk_cycle();
    #1;
    imem_bus.imem_rsp_valid = 1'b0;
    if (rst) begin
      m_out = 1'b0;
    end else if (force_rsp) begin
      imem_bus.imem_rsp_valid = 1'b1;
      imem_bus.imem_rsp_data  = 32'h0BAD_C0DE;
      force_rsp = 1'b0;
    end else if (m_out) begin
      m_cnt--;
      if (m_cnt == 0) begin
        imem_bus.imem_rsp_valid = 1'b1;
        imem_bus.imem_rsp_data  = memf(m_addr);
        m_out = 1'b0;
      end
    end
    case (ready_mode)
      0:       imem_bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      1:       imem_bus.imem_req_ready = 1'b1;
      default: imem_bus.imem_req_ready = 1'b0;
    endcase
    if (imem_bus.imem_req_valid && imem_bus.imem_req_ready) begin
      m_out  = 1'b1;
      m_addr = imem_bus.imem_addr;
      m_cnt  = (lat_fix != 0) ? lat_fix : $urandom_range(1, 4);
    end
    if (rst) exp_pc = RST_PC;
    else if (redirect_valid) exp_pc = redirect_addr & ~32'h3;
    else if (instr_valid && instr_ready) begin
      exp_pc = PCsrc ? ((exp_pc + ImmOp) & ~32'h3) : exp_pc + 32'd4;
      n_pres++;
    end
    @(posedge clk);
    #1;
    if (!rst) model_check();
  endtask

  task automatic wait_valid(input string tag);
    int unsigned n = 0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    while (!instr_valid && n < 20) begin
      clk_cycle();
      n++;
    end
    check_eq({tag, "_present"}, 32'(instr_valid), 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] a);
    instr_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr  = a;
    clk_cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] hold_i, hold_pc, r;
    int unsigned n;
    rst = 1'b1; instr_ready = 1'b0; PCsrc = 1'b0; ImmOp = '0;
    redirect_valid = 1'b0; redirect_addr = '0;
    imem_bus.imem_req_ready = 1'b0; imem_bus.imem_rsp_valid = 1'b0; imem_bus.imem_rsp_data = '0;
    exp_pc = RST_PC; m_out = 1'b0; m_addr = '0; m_cnt = 0;
    ready_mode = 1; lat_fix = 1; force_rsp = 1'b0; n_pres = 0;

    // reset state and first fetches with a 1-cycle memory
    repeat (2) clk_cycle();
    check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_instr", instr, INSTR_NOP);
    check_eq("rst_instr_pc", instr_pc, RST_PC);
    check_eq("rst_req_valid", 32'(imem_bus.imem_req_valid), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("c0_req_valid", 32'(imem_bus.imem_req_valid), 32'd1);
    check_eq("c0_addr", imem_bus.imem_addr, RST_PC);
    clk_cycle();
    check_eq("c1_instr_valid", 32'(instr_valid), 32'd0);
    clk_cycle();
    check_eq("c2_instr_valid", 32'(instr_valid), 32'd1);
    check_eq("c2_instr", instr, 32'h0050_0093);
    check_eq("c2_instr_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    clk_cycle();
    check_eq("c3_instr_valid", 32'(instr_valid), 32'd0);
    clk_cycle();
    check_eq("c4_instr_valid", 32'(instr_valid), 32'd0);
    clk_cycle();
    check_eq("c5_instr_valid", 32'(instr_valid), 32'd1);
    check_eq("c5_instr", instr, 32'h0010_0113);
    check_eq("c5_instr_pc", instr_pc, 32'h4);
    instr_ready = 1'b0;

    // backward branch, then an unaligned forward offset
    do_redirect(32'h10);
    wait_valid("br1");
    check_eq("br1_instr_pc", instr_pc, 32'h10);
    instr_ready = 1'b1; PCsrc = 1'b1; ImmOp = 32'hFFFF_FFF8;
    clk_cycle();
    instr_ready = 1'b0; PCsrc = 1'b0;
    check_eq("br1_req_valid", 32'(imem_bus.imem_req_valid), 32'd1);
    check_eq("br1_addr", imem_bus.imem_addr, 32'h08);
    wait_valid("br1_tgt");
    do_redirect(32'h10);
    wait_valid("br2");
    instr_ready = 1'b1; PCsrc = 1'b1; ImmOp = 32'h6;
    clk_cycle();
    instr_ready = 1'b0; PCsrc = 1'b0;
    check_eq("br2_addr", imem_bus.imem_addr, 32'h14);

    // downstream stall
    wait_valid("stall");
    hold_i = instr; hold_pc = instr_pc;
    repeat (10) begin
      clk_cycle();
      check_eq("stall_instr", instr, hold_i);
      check_eq("stall_pc", instr_pc, hold_pc);
      check_eq("stall_req", 32'(imem_bus.imem_req_valid), 32'd0);
    end
    instr_ready = 1'b1;
    clk_cycle();
    instr_ready = 1'b0;
    check_eq("stall_adv_valid", 32'(instr_valid), 32'd0);
    check_eq("stall_adv_addr", imem_bus.imem_addr, hold_pc + 32'd4);
    wait_valid("stall_next");
    check_eq("stall_next_pc", instr_pc, hold_pc + 32'd4);

    // squash of an in-flight fetch
    do_redirect(32'h20);
    lat_fix = 4;
    clk_cycle();
    check_eq("sq_issue_addr", m_addr, 32'h20);
    do_redirect(32'h100);
    n = 0;
    while (!imem_bus.imem_req_valid && n < 10) begin
      check_eq("sq_no_instr", 32'(instr_valid), 32'd0);
      clk_cycle();
      n++;
    end
    check_eq("sq_refetch_valid", 32'(imem_bus.imem_req_valid), 32'd1);
    check_eq("sq_refetch_addr", imem_bus.imem_addr, 32'h100);
    lat_fix = 1;
    wait_valid("sq");
    check_eq("sq_instr_pc", instr_pc, 32'h100);

    // redirect beats a taken branch in HOLD
    instr_ready = 1'b1; PCsrc = 1'b1; ImmOp = 32'h40;
    redirect_valid = 1'b1; redirect_addr = 32'h203;
    clk_cycle();
    instr_ready = 1'b0; PCsrc = 1'b0; redirect_valid = 1'b0;
    check_eq("rb_valid", 32'(instr_valid), 32'd0);
    check_eq("rb_addr", imem_bus.imem_addr, 32'h200);

    // wrap-around
    do_redirect(32'hFFFF_FFFC);
    wait_valid("wrap");
    instr_ready = 1'b1;
    clk_cycle();
    instr_ready = 1'b0;
    check_eq("wrap_addr", imem_bus.imem_addr, 32'h0);

    // reset while waiting, then a stray response in FETCH
    lat_fix = 3;
    clk_cycle();
    rst = 1'b1;
    clk_cycle();
    check_eq("mr_valid", 32'(instr_valid), 32'd0);
    check_eq("mr_req_in_rst", 32'(imem_bus.imem_req_valid), 32'd0);
    check_eq("mr_instr_pc", instr_pc, RST_PC);
    rst = 1'b0; force_rsp = 1'b1; ready_mode = 2;
    clk_cycle();
    check_eq("mr_late_valid", 32'(instr_valid), 32'd0);
    check_eq("mr_req", 32'(imem_bus.imem_req_valid), 32'd1);
    check_eq("mr_addr", imem_bus.imem_addr, RST_PC);
    ready_mode = 1; lat_fix = 1;
    wait_valid("mr");
    check_eq("mr_instr", instr, 32'h0050_0093);

    // randomized traffic against the reference model
    ready_mode = 0; lat_fix = 0; n_pres = 0;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom;
      instr_ready    = 1'($urandom_range(0, 1));
      PCsrc          = 1'($urandom_range(0, 1));
      ImmOp          = {{24{r[7]}}, r[7:0]};
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_addr  = $urandom;
      clk_cycle();
    end
    redirect_valid = 1'b0; instr_ready = 1'b0;
    check_eq("rand_progress", 32'(n_pres > 50), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
